// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the instruction-memory slave state encoding.
package ahb_pkg;

  // HTRANS encodings
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  // Size / burst encodings this slave cares about
  localparam logic [2:0] HSIZE_WORD   = 3'b010;
  localparam logic [2:0] HBURST_INCR4 = 3'b011;

  // HRESP encodings
  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  // Slave data-phase state (kept as plain constants for legacy tools)
  typedef logic [2:0] slave_state_t;
  localparam slave_state_t ST_IDLE = 3'd0;
  localparam slave_state_t ST_WAIT = 3'd1;
  localparam slave_state_t ST_DATA = 3'd2;
  localparam slave_state_t ST_ERR1 = 3'd3;
  localparam slave_state_t ST_ERR2 = 3'd4;

endpackage

// File: rtl/imem_sram.sv
// Word-wide synchronous SRAM: one registered read port, one write port.
// Contents are never reset so the array can be replaced by a foundry macro.
module imem_sram #(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          HCLK,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata
);

  logic [31:0] mem [DEPTH];

  // Write on we, registered read on re; rdata holds between reads.
  always_ff @(posedge HCLK) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/ahb_lite_imem_slave.sv
// AHB-Lite slave backing the instruction fetch path with on-chip SRAM.
// Programmable wait states for NONSEQ and SEQ data phases, two-cycle ERROR
// response for illegal transfers, and write-to-read forwarding.
//
// Handshake: a transfer is accepted at a rising edge when HREADY, HSEL and
// HTRANS[1] are all high while this slave is able to take a new address
// phase (IDLE, DATA or ERR2). Its data phase then ends at the first edge
// where HREADYOUT is high; HREADYOUT low stretches the data phase.
module ahb_lite_imem_slave
  import ahb_pkg::*;
#(
  parameter int unsigned MEM_BYTES   = 4096,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned NONSEQ_WAIT = 1,
  parameter int unsigned SEQ_WAIT    = 0
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [2:0]  HBURST,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic        HRESP
);

  localparam int AW    = $clog2(MEM_BYTES);
  localparam int IW    = AW - 2;
  localparam int DEPTH = MEM_BYTES / 4;

  // Where HRDATA comes from: reset zero, SRAM read register, or forwarded write
  localparam logic [1:0] SRC_ZERO = 2'd0;
  localparam logic [1:0] SRC_SRAM = 2'd1;
  localparam logic [1:0] SRC_FWD  = 2'd2;

  slave_state_t  state;
  slave_state_t  state_nxt;
  logic [3:0]    wait_cnt;
  logic [3:0]    wait_nxt;
  logic          dp_write;
  logic [IW-1:0] dp_index;
  logic [1:0]    rd_src;
  logic [31:0]   fwd_data;
  logic [31:0]   sram_rdata;

  logic          can_accept;
  logic          is_xfer;
  logic          accept;
  logic          legal;
  logic [3:0]    acc_wait;
  logic [IW-1:0] acc_index;
  logic          wr_done;
  logic          rd_issue;
  logic          fwd_hit;
  logic          unused_ok;

  // HBURST is accepted and ignored; IDLE/BUSY need no decoding beyond HTRANS[1].
  assign unused_ok = ^(HBURST ^ HBURST_INCR4) ^ (HTRANS == HTRANS_IDLE)
                     ^ (HTRANS == HTRANS_BUSY);

  assign can_accept = (state == ST_IDLE) || (state == ST_DATA) || (state == ST_ERR2);
  assign is_xfer    = (HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ);
  assign accept     = can_accept && HREADY && HSEL && is_xfer;
  assign legal      = (HSIZE == HSIZE_WORD) && (HADDR[1:0] == 2'b00)
                      && (HADDR[31:AW] == BASE_ADDR[31:AW]);
  assign acc_wait   = (HTRANS == HTRANS_SEQ) ? 4'(SEQ_WAIT) : 4'(NONSEQ_WAIT);
  assign acc_index  = HADDR[AW-1:2];

  // A write lands in the SRAM at the edge that ends its DATA phase
  assign wr_done  = (state == ST_DATA) && dp_write;
  assign rd_issue = accept && legal && !HWRITE;
  assign fwd_hit  = wr_done && (dp_index == acc_index);

  // Response outputs decoded from state
  assign HREADYOUT = !((state == ST_WAIT) || (state == ST_ERR1));
  assign HRESP     = ((state == ST_ERR1) || (state == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;

  // Next-state and wait-counter logic
  always_comb begin
    state_nxt = state;
    wait_nxt  = wait_cnt;
    case (state)
      ST_WAIT: begin
        if (wait_cnt <= 4'd1) begin
          state_nxt = ST_DATA;
          wait_nxt  = 4'd0;
        end else begin
          wait_nxt = wait_cnt - 4'd1;
        end
      end
      ST_ERR1: state_nxt = ST_ERR2;
      ST_IDLE, ST_DATA, ST_ERR2: begin
        if (accept) begin
          if (!legal) begin
            state_nxt = ST_ERR1;
          end else if (acc_wait != 4'd0) begin
            state_nxt = ST_WAIT;
            wait_nxt  = acc_wait;
          end else begin
            state_nxt = ST_DATA;
          end
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        wait_nxt  = 4'd0;
      end
    endcase
  end

  // State, data-phase capture and read-data source registers
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state    <= ST_IDLE;
      wait_cnt <= 4'd0;
      dp_write <= 1'b0;
      dp_index <= '0;
      rd_src   <= SRC_ZERO;
      fwd_data <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
      if (accept) begin
        // An illegal write never becomes a pending write
        dp_write <= HWRITE && legal;
        dp_index <= acc_index;
      end
      if (rd_issue) begin
        if (fwd_hit) begin
          rd_src   <= SRC_FWD;
          fwd_data <= HWDATA;
        end else begin
          rd_src <= SRC_SRAM;
        end
      end
    end
  end

  // Read data mux; every source is a register, so HRDATA holds between reads
  always_comb begin
    HRDATA = '0;
    case (rd_src)
      SRC_SRAM: HRDATA = sram_rdata;
      SRC_FWD:  HRDATA = fwd_data;
      default:  HRDATA = '0;
    endcase
  end

  imem_sram #(
    .DEPTH (DEPTH),
    .AW    (IW)
  ) u_sram (
    .HCLK  (HCLK),
    .re    (rd_issue && !fwd_hit),
    .raddr (acc_index),
    .rdata (sram_rdata),
    .we    (wr_done),
    .waddr (dp_index),
    .wdata (HWDATA)
  );

endmodule

// File: tb/tb_ahb_lite_imem_slave.sv
// Self-checking bench for ahb_lite_imem_slave: transaction-level model of
// memory contents, wait counts and responses.
module tb_ahb_lite_imem_slave;

  localparam int unsigned MEM_BYTES = 4096;
  localparam logic [31:0] BASE      = 32'h0000_0000;
  localparam int          NW        = 1;
  localparam int          SW        = 0;
  localparam int          LIMIT     = 4000;

  logic        HCLK;
  logic        HRESET;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic [31:0] HRDATA;
  logic        HREADYOUT;
  logic        HRESP;
  logic        stall;

  // Only slave on the bus; stall models another slave holding HREADY low
  assign HREADY = HREADYOUT & ~stall;

  ahb_lite_imem_slave #(
    .MEM_BYTES   (MEM_BYTES),
    .BASE_ADDR   (BASE),
    .NONSEQ_WAIT (NW),
    .SEQ_WAIT    (SW)
  ) dut (
    .HCLK      (HCLK),
    .HRESET    (HRESET),
    .HSEL      (HSEL),
    .HADDR     (HADDR),
    .HTRANS    (HTRANS),
    .HWRITE    (HWRITE),
    .HSIZE     (HSIZE),
    .HBURST    (HBURST),
    .HWDATA    (HWDATA),
    .HREADY    (HREADY),
    .HRDATA    (HRDATA),
    .HREADYOUT (HREADYOUT),
    .HRESP     (HRESP)
  );

  // Clock
  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  typedef struct packed {
    logic [1:0]  trans;
    logic        write;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
  } xfer_t;

  xfer_t       q[$];
  logic [31:0] mem_m [int];
  int          checks;
  int          errors;
  int          completed;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int idx(input logic [31:0] a);
    return int'((a - BASE) >> 2);
  endfunction

  function automatic bit illegal(input xfer_t x);
    longint unsigned a;
    a = longint'(x.addr);
    return (x.size != 3'b010) || (x.addr[1:0] != 2'b00) ||
           (a < longint'(BASE)) || (a >= longint'(BASE) + longint'(MEM_BYTES));
  endfunction

  task automatic push(input logic [1:0] t, input logic w, input logic [31:0] a,
                      input logic [2:0] s, input logic [31:0] d);
    xfer_t x;
    x.trans = t; x.write = w; x.addr = a; x.size = s; x.wdata = d;
    q.push_back(x);
  endtask

  task automatic bus_idle();
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HADDR = '0; HSIZE = 3'b010;
  endtask

  // Pipelined master: plays the queue, checks every data phase at its end
  task automatic run();
    bit          dp_v;
    xfer_t       dp;
    xfer_t       cur;
    int          dp_waits;
    int          exp_waits;
    bit          exp_err;
    logic [31:0] exp_data;
    int          guard;
    bit          acc;
    bit          consume;
    logic        rdy;
    dp_v = 0; guard = 0; completed = 0;
    dp_waits = 0; exp_waits = 0; exp_err = 0; exp_data = '0; dp = '0;
    while ((q.size() > 0 || dp_v) && guard < LIMIT) begin
      guard++;
      if (q.size() > 0) begin
        cur = q[0];
        HSEL = 1'b1; HTRANS = cur.trans; HWRITE = cur.write;
        HADDR = cur.addr; HSIZE = cur.size; HBURST = 3'b011;
      end else begin
        bus_idle();
      end
      @(negedge HCLK);
      rdy = HREADYOUT;
      if (dp_v) begin
        if (!rdy) begin
          dp_waits++;
          check("wait_resp", {31'b0, HRESP}, {31'b0, exp_err});
        end else begin
          completed++;
          check("wait_count", 32'(dp_waits), 32'(exp_waits));
          check("resp", {31'b0, HRESP}, {31'b0, exp_err});
          if (!exp_err && !dp.write) check("rdata", HRDATA, exp_data);
          if (!exp_err && dp.write) mem_m[idx(dp.addr)] = dp.wdata;
          dp_v = 0;
        end
      end else begin
        check("idle_ready", {31'b0, rdy}, 32'd1);
      end
      acc     = rdy && (q.size() > 0) && q[0].trans[1];
      consume = rdy && (q.size() > 0);
      @(posedge HCLK); #1;
      if (acc) begin
        dp        = q[0];
        dp_v      = 1;
        dp_waits  = 0;
        exp_err   = illegal(dp);
        exp_waits = exp_err ? 1 : ((dp.trans == 2'b11) ? SW : NW);
        if (!exp_err && !dp.write) exp_data = mem_m[idx(dp.addr)];
        if (dp.write) HWDATA = dp.wdata;
      end
      if (consume) void'(q.pop_front());
    end
    if (guard >= LIMIT) begin
      errors++;
      $error("FAIL run_timeout got=%0d exp<%0d", guard, LIMIT);
    end
    bus_idle();
  endtask

  initial begin
    logic [31:0] held;
    checks = 0; errors = 0; completed = 0; stall = 1'b0;
    HWDATA = '0; HBURST = 3'b011;
    bus_idle();

    // Reset
    HRESET = 1'b1;
    repeat (2) @(posedge HCLK);
    @(negedge HCLK);
    check("rst_ready", {31'b0, HREADYOUT}, 32'd1);
    check("rst_resp", {31'b0, HRESP}, 32'd0);
    check("rst_rdata", HRDATA, 32'd0);
    @(posedge HCLK); #1;
    HRESET = 1'b0;

    // Preload through bus writes
    push(2'b10, 1, 32'h10, 3'b010, 32'hDEAD_BEEF);
    push(2'b10, 1, 32'h20, 3'b010, 32'hA000_0020);
    push(2'b11, 1, 32'h24, 3'b010, 32'hA100_0024);
    push(2'b11, 1, 32'h28, 3'b010, 32'hA200_0028);
    push(2'b11, 1, 32'h2C, 3'b010, 32'hA300_002C);
    push(2'b10, 1, 32'h40, 3'b010, 32'h0000_0040);
    push(2'b10, 1, 32'h44, 3'b010, 32'h4444_0044);
    push(2'b10, 1, 32'h50, 3'b010, 32'h5555_5050);
    run();

    // Single NONSEQ read with one wait state
    push(2'b10, 0, 32'h10, 3'b010, 32'h0);
    run();

    // INCR4 read
    push(2'b10, 0, 32'h20, 3'b010, 32'h0);
    push(2'b11, 0, 32'h24, 3'b010, 32'h0);
    push(2'b11, 0, 32'h28, 3'b010, 32'h0);
    push(2'b11, 0, 32'h2C, 3'b010, 32'h0);
    run();
    check("incr4_beats", 32'(completed), 32'd4);

    // INCR4 with BUSY after beat 2
    push(2'b10, 0, 32'h20, 3'b010, 32'h0);
    push(2'b11, 0, 32'h24, 3'b010, 32'h0);
    push(2'b01, 0, 32'h28, 3'b010, 32'h0);
    push(2'b11, 0, 32'h28, 3'b010, 32'h0);
    push(2'b11, 0, 32'h2C, 3'b010, 32'h0);
    run();
    check("busy_beats", 32'(completed), 32'd4);

    // Write then immediate read of the same word, then a later read
    push(2'b10, 1, 32'h40, 3'b010, 32'h1234_5678);
    push(2'b10, 0, 32'h40, 3'b010, 32'h0);
    push(2'b00, 0, 32'h0,  3'b010, 32'h0);
    push(2'b10, 0, 32'h40, 3'b010, 32'h0);
    run();
    check("raw_model", mem_m[idx(32'h40)], 32'h1234_5678);

    // Error responses; errored write must leave memory unchanged
    push(2'b10, 0, BASE + MEM_BYTES, 3'b010, 32'h0);
    push(2'b00, 0, 32'h0,  3'b010, 32'h0);
    push(2'b10, 0, 32'h10, 3'b000, 32'h0);
    push(2'b00, 0, 32'h0,  3'b010, 32'h0);
    push(2'b10, 0, 32'h12, 3'b010, 32'h0);
    push(2'b00, 0, 32'h0,  3'b010, 32'h0);
    push(2'b10, 1, 32'h44, 3'b000, 32'h0BAD_0BAD);
    push(2'b00, 0, 32'h0,  3'b010, 32'h0);
    push(2'b10, 0, 32'h44, 3'b010, 32'h0);
    run();

    // HREADY held low by another slave: nothing accepted, HRDATA holds
    held = mem_m[idx(32'h44)];
    stall = 1'b1;
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = 32'h10; HSIZE = 3'b010;
    @(negedge HCLK);
    check("stall_ready0", {31'b0, HREADYOUT}, 32'd1);
    @(posedge HCLK); #1;
    @(negedge HCLK);
    check("stall_ready1", {31'b0, HREADYOUT}, 32'd1);
    check("stall_hold", HRDATA, held);
    @(posedge HCLK); #1;
    bus_idle();
    stall = 1'b0;
    @(negedge HCLK);
    check("stall_after", HRDATA, held);
    @(posedge HCLK); #1;

    // Reset during the wait state of a write: write abandoned
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 32'h50; HSIZE = 3'b010;
    @(posedge HCLK); #1;
    bus_idle();
    HWDATA = 32'hCAFE_F00D;
    @(negedge HCLK);
    check("wr_wait_low", {31'b0, HREADYOUT}, 32'd0);
    #1 HRESET = 1'b1;
    #1;
    check("async_ready", {31'b0, HREADYOUT}, 32'd1);
    check("async_resp", {31'b0, HRESP}, 32'd0);
    check("async_rdata", HRDATA, 32'd0);
    @(posedge HCLK); #1;
    HRESET = 1'b0;
    push(2'b10, 0, 32'h50, 3'b010, 32'h0);
    run();

    // Randomized traffic over a preloaded window
    for (int i = 0; i < 16; i++) begin
      push(2'b10, 1, 32'h100 + 32'(i * 4), 3'b010, $urandom);
    end
    run();
    for (int i = 0; i < 80; i++) begin
      int          kind;
      logic [31:0] a;
      logic [1:0]  t;
      kind = $urandom_range(0, 9);
      a    = 32'h100 + 32'($urandom_range(0, 15) * 4);
      t    = ($urandom_range(0, 1) == 1) ? 2'b11 : 2'b10;
      case (kind)
        0, 1, 2, 3: push(t, 0, a, 3'b010, 32'h0);
        4, 5, 6:    push(t, 1, a, 3'b010, $urandom);
        7:          push(2'b01, 0, a, 3'b010, 32'h0);
        8: begin
          if ($urandom_range(0, 1) == 1) push(t, $urandom_range(0, 1) == 1, a, 3'b001, $urandom);
          else push(t, $urandom_range(0, 1) == 1, 32'h2000 + a, 3'b010, $urandom);
        end
        default:    push(2'b00, 0, a, 3'b010, 32'h0);
      endcase
    end
    run();
    for (int i = 0; i < 16; i++) begin
      push(2'b10, 0, 32'h100 + 32'(i * 4), 3'b010, 32'h0);
    end
    run();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
